// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-mode constants and a
// width helper used to size counters in both the RX and TX engines.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to RST_VAL
// so an idle-high line does not look like a start edge coming out of reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled start detection with glitch rejection,
// mid-bit data sampling, parity/stop checks and a one-deep valid/ready output.
module uart_rx_core #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy,
  output logic [2:0]        state
);

  import uart_pkg::*;

  localparam int CNT_W = width_of(OVERSAMPLE);
  localparam int IDX_W = width_of(DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic             PAR_EN    = (PARITY_EN != 0);
  localparam logic             PAR_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : PARITY_EVEN;
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = RX_IDLE;
  localparam logic [2:0] S_START  = RX_START;
  localparam logic [2:0] S_DATA   = RX_DATA;
  localparam logic [2:0] S_PARITY = RX_PARITY;
  localparam logic [2:0] S_STOP   = RX_STOP;

  logic              rxs;
  logic [2:0]        state_q;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift;
  logic              perr;
  logic              ferr;
  logic              stop_idx;
  logic              bit_end;
  logic              done;
  logic              done_ferr;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  assign bit_end   = baud_tick && (cnt == CNT_LAST);
  assign done      = bit_end && (state_q == S_STOP) && (stop_idx == STOP_LAST);
  assign done_ferr = ferr | ~rxs;
  assign busy      = (state_q != S_IDLE);
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      stop_idx <= 1'b0;
    end else if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            cnt     <= '0;
          end
        end
        S_START: begin
          // Re-check the line at mid start bit; a high level means a glitch.
          if (cnt == CNT_MID) begin
            cnt      <= '0;
            idx      <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            stop_idx <= 1'b0;
            state_q  <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            shift <= {rxs, shift[DATA_W-1:1]};
            cnt   <= '0;
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) state_q <= PAR_EN ? S_PARITY : S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            perr    <= rxs ^ (^shift) ^ PAR_SENSE;
            cnt     <= '0;
            state_q <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            ferr     <= done_ferr;
            stop_idx <= stop_idx + 1'b1;
            if (stop_idx == STOP_LAST) state_q <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output stage: rx_valid/rx_ready handshake; data and flags are stable while
  // rx_valid is high. A completion finding the stage full and undrained is
  // dropped and reported on overrun_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift;
          parity_err <= perr;
          frame_err  <= done_ferr;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
